// File: rtl/serial_tx_arbiter_if.sv
// Request/serial bus of the shared LSB-first serial transmitter.
interface serial_tx_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ID_W   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]        req_vld_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_rdy_o;
  logic                    serial_o;
  logic                    valid_o;
  logic                    sof_o;
  logic [ID_W-1:0]         src_id_o;
  logic                    busy_o;

  // Transmitter side
  modport slave (
    input  req_vld_i, req_data_i,
    output req_rdy_o, serial_o, valid_o, sof_o, src_id_o, busy_o
  );

  // Requester / environment side
  modport master (
    output req_vld_i, req_data_i,
    input  req_rdy_o, serial_o, valid_o, sof_o, src_id_o, busy_o
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding one LSB-first shifter; the next grant is
// issued on the last bit of the current word so the stream has no bubbles.
module serial_tx_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  serial_tx_arbiter_if.slave bus
);
  localparam int unsigned     CNT_W   = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(DATA_W - 1);
  localparam logic [ID_W-1:0]  RR_INIT = ID_W'(N_REQ - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   src_q, src_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic              armed_q;

  logic [ID_W-1:0]   grant, cand;
  logic              found, grant_en, hs;
  logic [DATA_W-1:0] words [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_word
    assign words[i] = bus.req_data_i[i*DATA_W +: DATA_W];
  end

  // Grants are held off until the first edge after reset release, so every
  // output, rdy included, stays 0 in that first cycle.
  assign grant_en = armed_q & ((state_q == IDLE) | (cnt_q == LAST));
  assign hs       = grant_en & found;

  // Round-robin search starting just after the previous winner
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(rr_q) + k) % N_REQ);
      if (!found && bus.req_vld_i[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      src_q   <= '0;
      rr_q    <= RR_INIT;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      rr_q    <= rr_d;
      armed_q <= 1'b1;
    end
  end

  // Next-state: load on handshake, otherwise shift or retire the word
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    rr_d    = rr_q;
    if (hs) begin
      state_d = SHIFT;
      shift_d = words[grant];
      cnt_d   = '0;
      src_d   = grant;
      rr_d    = grant;
    end else if (state_q == SHIFT) begin
      if (cnt_q != LAST) begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
      end else begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.req_rdy_o = '0;
    if (hs) bus.req_rdy_o[grant] = 1'b1;
    bus.serial_o = shift_q[0];
    bus.valid_o  = (state_q == SHIFT);
    bus.busy_o   = (state_q == SHIFT);
    bus.sof_o    = (state_q == SHIFT) && (cnt_q == '0);
    bus.src_id_o = (state_q == SHIFT) ? src_q : '0;
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Randomized bench for serial_tx_arbiter against a queue-based stream model.
module tb_serial_tx_arbiter;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned ID_W   = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  serial_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  serial_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // One expected beat of the serial stream
  typedef struct packed {
    logic            b;
    logic            sof;
    logic [ID_W-1:0] id;
  } beat_t;

  beat_t             exp_q[$];
  int                rr;
  int                errors = 0;
  int                checks = 0;
  logic [N_REQ-1:0]  vld;
  logic [DATA_W-1:0] data [N_REQ];
  int                grant_log[$];
  logic              bit_log[$];
  int                run, max_run;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    bit_log.delete();
    run = 0;
    max_run = 0;
  endtask

  // Reset pulse mid-cycle; outputs must drop at once
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_rdy",    bus.req_rdy_o, '0);
    check_eq("rst_serial", bus.serial_o,  0);
    check_eq("rst_valid",  bus.valid_o,   0);
    check_eq("rst_sof",    bus.sof_o,     0);
    check_eq("rst_src",    bus.src_id_o,  0);
    check_eq("rst_busy",   bus.busy_o,    0);
    vld = '0;
    bus.req_vld_i = '0;
    exp_q.delete();
    rr = N_REQ - 1;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("rel_valid", bus.valid_o, 0);
    check_eq("rel_serial", bus.serial_o, 0);
    @(posedge clk);
  endtask

  // One clock: drive inputs, predict and compare, then advance the model
  task automatic step(output int g);
    logic [N_REQ-1:0] exp_rdy;
    beat_t cur;
    @(negedge clk);
    bus.req_vld_i = vld;
    for (int i = 0; i < N_REQ; i++) bus.req_data_i[i*DATA_W +: DATA_W] = data[i];
    #1;
    g = -1;
    exp_rdy = '0;
    if (exp_q.size() <= 1) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (rr + k) % N_REQ;
        if (g < 0 && vld[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    cur = (exp_q.size() > 0) ? exp_q[0] : '0;
    check_eq("rdy",    bus.req_rdy_o, exp_rdy);
    check_eq("valid",  bus.valid_o,   exp_q.size() > 0);
    check_eq("busy",   bus.busy_o,    exp_q.size() > 0);
    check_eq("serial", bus.serial_o,  cur.b);
    check_eq("sof",    bus.sof_o,     cur.sof);
    check_eq("src_id", bus.src_id_o,  cur.id);
    for (int i = 0; i < N_REQ; i++) if (bus.req_rdy_o[i]) grant_log.push_back(i);
    if (bus.valid_o) begin
      bit_log.push_back(bus.serial_o);
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (g >= 0) begin
      rr = g;
      for (int b = 0; b < DATA_W; b++) begin
        beat_t nb;
        nb.b   = data[g][b];
        nb.sof = (b == 0);
        nb.id  = ID_W'(g);
        exp_q.push_back(nb);
      end
    end
  endtask

  function automatic logic [31:0] bits_word(input int first, input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w[i] = bit_log[first + i];
    return w;
  endfunction

  initial begin
    int g;
    vld = '0;
    for (int i = 0; i < N_REQ; i++) data[i] = '0;
    bus.req_vld_i  = '0;
    bus.req_data_i = '0;
    rr = N_REQ - 1;

    // Single word from requester 0
    do_reset();
    clear_logs();
    vld = 4'b0001; data[0] = 4'hA;
    step(g);
    vld = '0;
    for (int c = 0; c < 6; c++) step(g);
    check_eq("t1_grants", grant_log.size(), 1);
    check_eq("t1_word", bits_word(0, 4), 32'hA);
    check_eq("t1_len", bit_log.size(), 4);

    // Two requesters pending from reset: 1 then 2, no gap
    do_reset();
    clear_logs();
    vld = 4'b0110; data[1] = 4'h3; data[2] = 4'hC;
    for (int c = 0; c < 11; c++) begin
      step(g);
      if (g >= 0) vld[g] = 1'b0;
    end
    check_eq("t2_g0", grant_log[0], 1);
    check_eq("t2_g1", grant_log[1], 2);
    check_eq("t2_stream", bits_word(0, 8), 32'hC3);
    check_eq("t2_run", max_run, 8);

    // All valid, re-asserting: strict rotation
    do_reset();
    clear_logs();
    vld = 4'b1111;
    for (int i = 0; i < N_REQ; i++) data[i] = DATA_W'($urandom);
    for (int c = 0; c < 25; c++) begin
      step(g);
      if (g >= 0) data[g] = DATA_W'($urandom);
    end
    for (int i = 0; i < 6; i++) check_eq("t3_order", grant_log[i], i % N_REQ);
    check_eq("t3_run", max_run >= 24, 1);

    // Requester 0 back-to-back, then requester 3 joins during word 2
    do_reset();
    clear_logs();
    vld = 4'b0001; data[0] = 4'h6;
    for (int c = 0; c < 14; c++) begin
      step(g);
      if (grant_log.size() == 2 && !vld[3] && g >= 0) begin vld[3] = 1'b1; data[3] = 4'h9; end
      if (g == 3) vld = '0;
    end
    check_eq("t4_g0", grant_log[0], 0);
    check_eq("t4_g1", grant_log[1], 0);
    check_eq("t4_g2", grant_log[2], 3);
    check_eq("t4_run", max_run, 12);

    // Reset during bit 2 of word F from requester 2
    do_reset();
    clear_logs();
    vld = 4'b0100; data[2] = 4'hF;
    step(g);
    step(g);
    step(g);
    vld = 4'b0100;
    do_reset();
    clear_logs();
    vld = 4'b0101; data[0] = 4'h5; data[2] = 4'hF;
    for (int c = 0; c < 6; c++) begin
      step(g);
      if (g >= 0) vld[g] = 1'b0;
    end
    check_eq("t5_first", grant_log[0], 0);

    // Requester 1 asserts mid-word and withdraws before the grant window
    do_reset();
    clear_logs();
    vld = 4'b0001; data[0] = 4'h7;
    step(g);
    vld = '0;
    step(g);
    vld[1] = 1'b1; data[1] = 4'h2;
    step(g);
    step(g);
    vld[1] = 1'b0;
    for (int c = 0; c < 3; c++) step(g);
    check_eq("t6_grants", grant_log.size(), 1);
    check_eq("t6_idle", bus.valid_o, 0);

    // Random traffic obeying the requester rules
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!vld[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            vld[i]  = 1'b1;
            data[i] = DATA_W'($urandom);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          vld[i] = 1'b0;
        end
      end
      step(g);
      if (g >= 0) begin
        vld[g]  = ($urandom_range(0, 1) == 1);
        data[g] = DATA_W'($urandom);
      end
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
